// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB3 completer exposing a bank of 32-bit registers.
// The last register is a read-only count of committed writes. Every transfer
// is held in PREADY-low wait states for a fixed number of access cycles, and
// illegal accesses (misaligned, out of range, or writes to the counter) are
// flagged with PSLVERR. All APB response outputs come straight from flops.
module apb_reg_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hA000,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              paddr,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [31:0]              pwdata,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int                IDX_W  = $clog2(NUM_REGS);
  localparam logic [31:0]       SPAN   = 32'(NUM_REGS * 4);
  localparam logic [IDX_W-1:0]  CNT_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [3:0]        WAIT_C = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       regs [NUM_REGS];

  logic [IDX_W-1:0]  lat_idx;
  logic              lat_write;
  logic              lat_legal;
  logic [31:0]       lat_wdata;

  logic [31:0]       off;
  logic [IDX_W-1:0]  idx_now;
  logic              legal_now;
  logic [31:0]       setup_rdata;
  logic [31:0]       access_rdata;

  // Decode the live bus address; only consumed at the SETUP edge.
  always_comb begin
    off         = paddr - BASE_ADDR;
    idx_now     = off[IDX_W+1:2];
    legal_now   = (paddr[1:0] == 2'b00) && (off < SPAN) &&
                  !(pwrite && (idx_now == CNT_IDX));
    setup_rdata = (!pwrite && legal_now) ? regs[idx_now] : 32'd0;
  end

  // Read data for the latched transfer, loaded when pready rises after waits.
  always_comb begin
    access_rdata = (!lat_write && lat_legal) ? regs[lat_idx] : 32'd0;
  end

  // Transfer FSM: latches the request at SETUP, counts wait states, commits writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_legal <= 1'b0;
      lat_wdata <= 32'd0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= 32'd0;
      wr_pulse  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 32'd0;
      end
    end else begin
      wr_pulse <= '0;
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state     <= ACCESS;
            cnt       <= 4'd0;
            lat_idx   <= idx_now;
            lat_write <= pwrite;
            lat_legal <= legal_now;
            lat_wdata <= pwdata;
            if (WAIT_C == 4'd0) begin
              pready  <= 1'b1;
              pslverr <= !legal_now;
              prdata  <= setup_rdata;
            end
          end
        end
        ACCESS: begin
          if (!psel) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= 32'd0;
          end else if (penable) begin
            if (!pready) begin
              cnt <= cnt + 4'd1;
              if ((cnt + 4'd1) == WAIT_C) begin
                pready  <= 1'b1;
                pslverr <= !lat_legal;
                prdata  <= access_rdata;
              end
            end else begin
              state   <= IDLE;
              pready  <= 1'b0;
              pslverr <= 1'b0;
              prdata  <= 32'd0;
              if (lat_write && lat_legal) begin
                regs[lat_idx]       <= lat_wdata;
                regs[NUM_REGS-1]    <= regs[NUM_REGS-1] + 32'd1;
                wr_pulse[lat_idx]   <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flatten the register bank for downstream consumers.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs[g];
  end

endmodule
